tea_core_arbiter: RTL and testbench

- Shares one tiny_encryption_algorithm core between N_REQ independent requesters.
- Round-robin arbitration of valid/ready request channels; issues a single-cycle ptxt_valid/key_valid pulse to the core; waits for ctxt_ready; returns ciphertext plus requester ID on one shared response channel.
- Sits between client blocks and the core instance; the core is unmodified.

---
 rtl/tea_arb_pkg.sv | 23 ++
 rtl/tea_rr_picker.sv | 32 +++
 rtl/tea_core_arbiter.sv | 161 ++++++++++++++++
 tb/tb_tea_core_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_arb_pkg.sv
// Shared types and constants for the TEA core arbiter.
package tea_arb_pkg;

   localparam int TEA_BLK_W = 64;
   localparam int TEA_KEY_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_e;

   typedef struct packed {
      logic [TEA_BLK_W-1:0] ptxt;
      logic [TEA_KEY_W-1:0] key;
   } tea_req_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tea_rr_picker.sv
// Round-robin picker: first valid requester found cyclically from ptr_i.
module tea_rr_picker #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [ID_W-1:0]  grant_idx_o,
   output logic [N_REQ-1:0] grant_oh_o,
   output logic             any_valid_o
);

   logic [ID_W:0]   sum_w;
   logic [ID_W-1:0] idx;

   always_comb begin
      grant_idx_o = '0;
      grant_oh_o  = '0;
      sum_w       = '0;
      idx         = '0;
      any_valid_o = |req_valid_i;
      // Scan farthest-first so the candidate nearest the pointer wins last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sum_w = {1'b0, ptr_i} + (ID_W+1)'(k);
         if (sum_w >= (ID_W+1)'(N_REQ)) sum_w = sum_w - (ID_W+1)'(N_REQ);
         idx = sum_w[ID_W-1:0];
         if (req_valid_i[idx]) grant_idx_o = idx;
      end
      if (any_valid_o) grant_oh_o[grant_idx_o] = 1'b1;
   end

endmodule

// File: rtl/tea_core_arbiter.sv
// Shares one TEA core between N_REQ requesters, one operation in flight.
// Optional WAIT watchdog built when TEA_ARB_TIMEOUT_EN is defined.
module tea_core_arbiter
   import tea_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int ID_W        = $clog2(N_REQ),
   parameter int MIN_LAT     = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*TEA_BLK_W-1:0] req_ptxt,
   input  logic [N_REQ*TEA_KEY_W-1:0] req_key,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_W-1:0]            rsp_id,
   output logic [TEA_BLK_W-1:0]       rsp_ctxt,
   output logic                       rsp_err,
   output logic                       core_ptxt_valid,
   output logic                       core_key_valid,
   output logic [TEA_BLK_W-1:0]       core_ptxt_blk,
   output logic [TEA_KEY_W-1:0]       core_key,
   input  logic [TEA_BLK_W-1:0]       core_ctxt_blk,
   input  logic                       core_ctxt_ready
);

   // Counter stops at CNT_SAT; without the watchdog it only needs to reach MIN_LAT.
`ifdef TEA_ARB_TIMEOUT_EN
   localparam int CNT_SAT = max_int(MIN_LAT, TIMEOUT_CYC);
`else
   localparam int CNT_SAT = MIN_LAT;
`endif
   localparam int CNT_W = $clog2(max_int(MIN_LAT, TIMEOUT_CYC) + 2);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   tea_req_t         req_q, req_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] wait_n;
   logic [TEA_BLK_W-1:0] ctxt_q, ctxt_d;
   logic             ctxt_qual;

   logic [ID_W-1:0]  grant_idx;
   logic [N_REQ-1:0] grant_oh;
   logic             any_valid;

`ifdef TEA_ARB_TIMEOUT_EN
   logic err_q, err_d;
`endif

   tea_rr_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .req_valid_i (req_valid),
      .ptr_i       (ptr_q),
      .grant_idx_o (grant_idx),
      .grant_oh_o  (grant_oh),
      .any_valid_o (any_valid)
   );

   // wait_n is the ordinal of the current WAIT cycle (1 on the cycle after the pulse).
   assign wait_n    = cnt_q + CNT_W'(1);
   assign ctxt_qual = core_ctxt_ready && (wait_n >= CNT_W'(MIN_LAT));

   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      id_d            = id_q;
      req_d           = req_q;
      cnt_d           = cnt_q;
      ctxt_d          = ctxt_q;
`ifdef TEA_ARB_TIMEOUT_EN
      err_d           = err_q;
`endif
      req_ready       = '0;
      core_ptxt_valid = 1'b0;
      core_key_valid  = 1'b0;
      rsp_valid       = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = grant_oh;
            if (any_valid) begin
               id_d     = grant_idx;
               req_d.ptxt = req_ptxt[grant_idx*TEA_BLK_W +: TEA_BLK_W];
               req_d.key  = req_key[grant_idx*TEA_KEY_W +: TEA_KEY_W];
               ptr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            core_ptxt_valid = 1'b1;
            core_key_valid  = 1'b1;
            cnt_d           = '0;
            state_d         = WAIT;
         end
         WAIT: begin
            if (cnt_q != CNT_W'(CNT_SAT)) cnt_d = wait_n;
            if (ctxt_qual) begin
               ctxt_d  = core_ctxt_blk;
`ifdef TEA_ARB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = RESP;
            end
`ifdef TEA_ARB_TIMEOUT_EN
            else if (wait_n >= CNT_W'(TIMEOUT_CYC)) begin
               ctxt_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
`endif
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         req_q   <= '0;
         cnt_q   <= '0;
         ctxt_q  <= '0;
`ifdef TEA_ARB_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         ctxt_q  <= ctxt_d;
`ifdef TEA_ARB_TIMEOUT_EN
         err_q   <= err_d;
`endif
      end
   end

   assign core_ptxt_blk = req_q.ptxt;
   assign core_key      = req_q.key;
   assign rsp_id        = id_q;
   assign rsp_ctxt      = ctxt_q;
`ifdef TEA_ARB_TIMEOUT_EN
   assign rsp_err       = err_q;
`else
   assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_tea_core_arbiter.sv
// Directed bench for tea_core_arbiter with a behavioural TEA core and a response scoreboard.
module tb_tea_core_arbiter;
   import tea_arb_pkg::*;

   localparam int N_REQ   = 4;
   localparam int ID_W    = 2;
   localparam int MIN_LAT = 2;
`ifdef TEA_ARB_TIMEOUT_EN
   localparam int TO_CYC  = 16;
`else
   localparam int TO_CYC  = 1024;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     req_ready;
   logic [N_REQ*64-1:0]  req_ptxt;
   logic [N_REQ*128-1:0] req_key;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [63:0]          rsp_ctxt;
   logic                 rsp_err;
   logic                 core_ptxt_valid;
   logic                 core_key_valid;
   logic [63:0]          core_ptxt_blk;
   logic [127:0]         core_key;
   logic [63:0]          core_ctxt_blk   = '0;
   logic                 core_ctxt_ready = 1'b0;

   always #5 clk = ~clk;

   tea_core_arbiter #(
      .N_REQ       (N_REQ),
      .ID_W        (ID_W),
      .MIN_LAT     (MIN_LAT),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_ptxt        (req_ptxt),
      .req_key         (req_key),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_id          (rsp_id),
      .rsp_ctxt        (rsp_ctxt),
      .rsp_err         (rsp_err),
      .core_ptxt_valid (core_ptxt_valid),
      .core_key_valid  (core_key_valid),
      .core_ptxt_blk   (core_ptxt_blk),
      .core_key        (core_key),
      .core_ctxt_blk   (core_ctxt_blk),
      .core_ctxt_ready (core_ctxt_ready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] tea(input logic [63:0] pt, input logic [127:0] k);
      logic [31:0] v0, v1, sum;
      v0 = pt[63:32];
      v1 = pt[31:0];
      sum = '0;
      for (int r = 0; r < 32; r++) begin
         sum = sum + 32'h9e3779b9;
         v0 = v0 + ((((v1 << 4) + k[127:96]) ^ (v1 + sum)) ^ ((v1 >> 5) + k[95:64]));
         v1 = v1 + ((((v0 << 4) + k[63:32]) ^ (v0 + sum)) ^ ((v0 >> 5) + k[31:0]));
      end
      return {v0, v1};
   endfunction

   // Mock core: mode 0 normal, 1 ready held high with late data, 2 never ready.
   int mode = 0;
   int lat  = 4;
   logic [63:0] pend = '0;
   int dly = 0;
   always @(posedge clk) begin
      if (core_ptxt_valid) begin
         pend <= tea(core_ptxt_blk, core_key);
         dly  <= (mode == 1) ? 5 : lat;
         if (mode != 1) core_ctxt_ready <= 1'b0;
      end else if (dly > 0) begin
         dly <= dly - 1;
         if (dly == 1) begin
            core_ctxt_blk <= pend;
            if (mode != 2) core_ctxt_ready <= 1'b1;
         end
      end
   end

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [63:0]     ctxt;
      logic            err;
   } exp_t;

   exp_t sb_q[$];
   int   grant_q[$];
   exp_t mon_e;
   int   pulse_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (core_ptxt_valid) pulse_cnt++;
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               mon_e.id   = ID_W'(i);
               mon_e.err  = (mode == 2);
               mon_e.ctxt = (mode == 2) ? 64'h0 :
                            (mode == 1) ? core_ctxt_blk :
                            tea(req_ptxt[64*i +: 64], req_key[128*i +: 128]);
               sb_q.push_back(mon_e);
               grant_q.push_back(i);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("sb_id", rsp_id, mon_e.id);
               chk("sb_ctxt", rsp_ctxt, mon_e.ctxt);
               chk("sb_err", rsp_err, mon_e.err);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input string tag, input int budget);
      int n = 0;
      while (!rsp_valid && n < budget) begin
         tick();
         n++;
      end
      chk(tag, rsp_valid, 1'b1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk(tag, sb_q.size(), 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pc0;
      logic [63:0] exp_c;
      rst_n     = 1'b0;
      req_valid = '0;
      req_ptxt  = '0;
      req_key   = '0;
      rsp_ready = 1'b0;
      repeat (3) tick();
      chk("reset_outs", {req_ready, rsp_valid, rsp_id, rsp_ctxt, rsp_err,
                         core_ptxt_valid, core_key_valid}, '0);
      chk("reset_core_bus", {core_ptxt_blk, core_key}, '0);
      rst_n = 1'b1;
      tick();

      // Single request on requester 2, zero key and plaintext.
      rsp_ready = 1'b1;
      pc0 = pulse_cnt;
      req_valid = 4'b0100;
      #1;
      chk("t1_req_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      chk("t1_issue", {core_ptxt_valid, core_key_valid, req_ready}, {1'b1, 1'b1, 4'b0000});
      tick();
      chk("t1_pulse_end", {core_ptxt_valid, core_key_valid}, 2'b00);
      wait_rsp("t1_rsp_seen", 50);
      chk("t1_kat_ctxt", rsp_ctxt, 64'h41ea3a0a94baa940);
      chk("t1_kat_id", rsp_id, 2'd2);
      chk("t1_kat_err", rsp_err, 1'b0);
      drain("t1_drain");
      chk("t1_one_pulse", pulse_cnt - pc0, 1);

      // Fairness from a freshly reset pointer.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      grant_q.delete();
      for (int i = 0; i < N_REQ; i++) begin
         req_ptxt[64*i +: 64]   = {$urandom, $urandom};
         req_key[128*i +: 128]  = {$urandom, $urandom, $urandom, $urandom};
      end
      req_valid = 4'b1111;
      for (int n = 0; n < 300 && grant_q.size() < 5; n++) tick();
      req_valid = '0;
      drain("rr_drain");
      chk("rr_count", grant_q.size(), 5);
      for (int j = 0; j < 5; j++) chk("rr_order", grant_q[j], j % N_REQ);

      // Backpressure: pointer now 1, requesters 0 and 1 valid -> grant 1 first.
      rsp_ready = 1'b0;
      req_valid = 4'b0011;
      exp_c = tea(req_ptxt[64 +: 64], req_key[128 +: 128]);
      wait_rsp("bp_rsp_seen", 50);
      for (int c = 0; c < 20; c++) begin
         chk("bp_hold", {rsp_valid, rsp_id, rsp_ctxt, req_ready}, {1'b1, 2'd1, exp_c, 4'b0000});
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_regrant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      drain("bp_drain");

      // Ready held high by the core: capture on the second WAIT cycle with stale data.
      mode = 1;
      req_valid = 4'b0010;
      #1;
      chk("st_req_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      chk("st_issue", core_ptxt_valid, 1'b1);
      tick();
      chk("st_wait1", rsp_valid, 1'b0);
      tick();
      chk("st_wait2", rsp_valid, 1'b0);
      tick();
      chk("st_resp", rsp_valid, 1'b1);
      drain("st_drain");
      mode = 0;
      repeat (8) tick();

      // Reset during WAIT aborts the operation.
      lat = 10;
      req_valid = 4'b0100;
      #1;
      chk("ab_req_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("ab_outs", {req_ready, rsp_valid, rsp_id, rsp_ctxt, rsp_err,
                      core_ptxt_valid, core_key_valid}, '0);
      chk("ab_core_bus", {core_ptxt_blk, core_key}, '0);
      sb_q.delete();
      req_valid = 4'b1111;
      #1;
      chk("ab_ptr_zero", req_ready, 4'b0001);
      req_valid = '0;
      for (int c = 0; c < 15; c++) begin
         tick();
         chk("ab_no_rsp", rsp_valid, 1'b0);
      end
      lat = 4;

`ifdef TEA_ARB_TIMEOUT_EN
      // Watchdog: core never ready, RESP after exactly TO_CYC WAIT cycles.
      mode = 2;
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      for (int k = 1; k <= TO_CYC; k++) tick();
      chk("to_wait_end", rsp_valid, 1'b0);
      tick();
      chk("to_resp", {rsp_valid, rsp_err, rsp_ctxt}, {1'b1, 1'b1, 64'h0});
      drain("to_drain");
      mode = 0;
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      wait_rsp("to_next_seen", 50);
      chk("to_next_err", rsp_err, 1'b0);
      drain("to_next_drain");
`endif

      repeat (5) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
